// File: rtl/connection_scheduler.sv
// rtl/connection_scheduler.sv - round-robin TX sequencing, busy timeout and RX drain in front of connection_module
module connection_scheduler #(
    parameter int                   DATA_WIDTH   = 8,
    parameter int                   REG_WIDTH    = 8,
    parameter logic [REG_WIDTH-1:0] PRESCALE_RST = 8'd4,
    parameter int                   BUSY_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [1:0]            req_i,
    input  logic [DATA_WIDTH-1:0] req_data0_i,
    input  logic [DATA_WIDTH-1:0] req_data1_i,
    output logic [1:0]            gnt_o,
    output logic                  tx_err_o,
    input  logic                  err_clr_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    input  logic                  cfg_we_i,
    input  logic [REG_WIDTH-1:0]  cfg_prescale_i,
    output logic [REG_WIDTH-1:0]  cmd_reg_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [REG_WIDTH-1:0]  pre_reg_o,
    input  logic [REG_WIDTH-1:0]  status_reg_i,
    input  logic [DATA_WIDTH-1:0] data_i
);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} tx_state_t;
    typedef enum logic {R_IDLE, R_CLR} rx_state_t;

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    tx_state_t             r_tx_state, w_tx_next;
    rx_state_t             r_rx_state, w_rx_next;
    logic                  r_ptr;
    logic [CW-1:0]         r_cnt;
    logic                  r_pend_vld;
    logic [REG_WIDTH-1:0]  r_pend;
    logic                  r_rdy_m, r_rdy_s;
    logic [1:0]            r_gnt;
    logic                  r_err, r_start, r_clr, r_rx_valid;
    logic [DATA_WIDTH-1:0] r_data, r_rx_data;
    logic [REG_WIDTH-1:0]  r_pre;

    logic w_grant, w_sel, w_timeout, w_apply, w_capture;
    logic w_unused_status;

    assign w_unused_status = ^status_reg_i[REG_WIDTH-1:2];

    // A pending prescaler write takes the first IDLE cycle, so no grant happens then.
    always_comb begin
        w_tx_next = r_tx_state;
        w_grant   = 1'b0;
        w_sel     = r_ptr;
        w_timeout = 1'b0;
        w_apply   = 1'b0;
        case (r_tx_state)
            IDLE: begin
                w_apply = r_pend_vld;
                if (!r_pend_vld && (req_i != 2'b00) && !status_reg_i[0]) begin
                    w_grant   = 1'b1;
                    w_sel     = req_i[r_ptr] ? r_ptr : ~r_ptr;
                    w_tx_next = START;
                end
            end
            START:     w_tx_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (status_reg_i[0]) begin
                    w_tx_next = WAIT_DONE;
                end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_tx_next = IDLE;
                end
            end
            WAIT_DONE: if (!status_reg_i[0]) w_tx_next = IDLE;
            default:   w_tx_next = IDLE;
        endcase
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_capture = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                if (r_rdy_s && !r_rx_valid) begin
                    w_capture = 1'b1;
                    w_rx_next = R_CLR;
                end
            end
            R_CLR:   if (!r_rdy_s) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_tx_state <= IDLE;
            r_rx_state <= R_IDLE;
            r_ptr      <= 1'b0;
            r_cnt      <= '0;
            r_pend_vld <= 1'b0;
            r_pend     <= '0;
            r_rdy_m    <= 1'b0;
            r_rdy_s    <= 1'b0;
            r_gnt      <= 2'b00;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
            r_clr      <= 1'b0;
            r_rx_valid <= 1'b0;
            r_data     <= '0;
            r_rx_data  <= '0;
            r_pre      <= PRESCALE_RST;
        end else begin
            r_tx_state <= w_tx_next;
            r_rx_state <= w_rx_next;
            r_gnt      <= 2'b00;
            r_start    <= w_grant;
            r_clr      <= w_capture;
            if (w_grant) begin
                r_gnt  <= w_sel ? 2'b10 : 2'b01;
                r_data <= w_sel ? req_data1_i : req_data0_i;
                r_ptr  <= ~w_sel;
            end
            if (r_tx_state == START) begin
                r_cnt <= '0;
            end else if (r_tx_state == WAIT_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
            if (cfg_we_i) begin
                if (r_tx_state == IDLE) begin
                    r_pre      <= cfg_prescale_i;
                    r_pend_vld <= 1'b0;
                end else begin
                    r_pend     <= cfg_prescale_i;
                    r_pend_vld <= 1'b1;
                end
            end else if (w_apply) begin
                r_pre      <= r_pend;
                r_pend_vld <= 1'b0;
            end
            // Data-ready is raised asynchronously by connection_module.
            r_rdy_m <= status_reg_i[1];
            r_rdy_s <= r_rdy_m;
            if (w_capture) begin
                r_rx_data  <= data_i;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign gnt_o      = r_gnt;
    assign tx_err_o   = r_err;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign cmd_reg_o  = {{(REG_WIDTH-2){1'b0}}, r_clr, r_start};
    assign data_o     = r_data;
    assign pre_reg_o  = r_pre;

endmodule
